// File: rtl/uart_ctrl_pkg.sv
// Shared UART control definitions: scheduler state encoding and frame bit counts.
package uart_ctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE = 2'd0;
    localparam state_t S_SEND = 2'd1;
    localparam state_t S_GAP  = 2'd2;

    localparam int unsigned START_BITS  = 1;
    localparam int unsigned DATA_BITS   = 8;
    localparam int unsigned PARITY_BITS = 1;
    localparam int unsigned STOP_BITS   = 1;
    localparam int unsigned FRAME_BITS  = START_BITS + DATA_BITS + PARITY_BITS + STOP_BITS;

    // One preparation cycle precedes the serial bits of every frame.
    localparam int unsigned PREP_CYCLES      = 1;
    localparam int unsigned FRAME_CYCLES_DEF = PREP_CYCLES + FRAME_BITS;

    // Index width for n requesters, never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Pointer-based round-robin picker: first valid index at or after i_ptr, wrapping.
module uart_rr_pick
    import uart_ctrl_pkg::*;
#(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned ID_W  = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]  i_ptr,
    output logic             o_found_c,
    output logic [ID_W-1:0]  o_index_c
);

    logic [ID_W-1:0] w_cand;

    // Walk ptr, ptr+1, ... and keep the first valid candidate.
    always_comb begin
        o_found_c = 1'b0;
        o_index_c = '0;
        w_cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            w_cand = ID_W'((32'(i_ptr) + k) % N_REQ);
            if (!o_found_c && i_valid[w_cand]) begin
                o_found_c = 1'b1;
                o_index_c = w_cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART transmitter among N_REQ byte producers.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter  int unsigned N_REQ        = 4,
    parameter  int unsigned FRAME_CYCLES = FRAME_CYCLES_DEF,
    parameter  int unsigned GAP_CYCLES   = 2,
    parameter  int unsigned CNT_W        = 5,
    localparam int unsigned ID_W         = id_width(N_REQ)
) (
    input  logic                 UART_CLK,
    input  logic                 UART_RST_N,
    input  logic [N_REQ-1:0]     REQ_VALID,
    input  logic [8*N_REQ-1:0]   REQ_DATA,
    output logic [N_REQ-1:0]     REQ_READY,
    output logic                 UART_IDLE,
    output logic [7:0]           UART_DATA,
    output logic [ID_W-1:0]      GRANT_ID,
    output logic                 BUSY,
    output logic                 FRAME_DONE
);

    localparam int unsigned LAST_FRAME = FRAME_CYCLES - 1;
    localparam int unsigned LAST_GAP   = (GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1;
    localparam bit          HAS_GAP    = (GAP_CYCLES != 0);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    w_ptr_nxt;

    logic [N_REQ-1:0]   r_ready;
    logic               r_idle;
    logic [7:0]         r_data;
    logic [ID_W-1:0]    r_id;
    logic               r_busy;
    logic               r_done;

    logic [N_REQ-1:0]   w_ready_nxt;
    logic               w_idle_nxt;
    logic [7:0]         w_data_nxt;
    logic [ID_W-1:0]    w_id_nxt;
    logic               w_busy_nxt;
    logic               w_done_nxt;

    logic               w_found;
    logic [ID_W-1:0]    w_pick;
    logic [7:0]         w_bytes [N_REQ];
    logic               w_frame_last;
    logic               w_gap_last;

    uart_rr_pick #(
        .N_REQ      (N_REQ)
    ) u_pick (
        .i_valid    (REQ_VALID),
        .i_ptr      (r_ptr),
        .o_found_c  (w_found),
        .o_index_c  (w_pick)
    );

    // Split the flat data bus into per-requester bytes.
    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            w_bytes[i] = REQ_DATA[8*i +: 8];
        end
    end

    assign w_frame_last = (r_cnt == CNT_W'(LAST_FRAME));
    assign w_gap_last   = (r_cnt == CNT_W'(LAST_GAP));

    // State, counter, pointer and output registers; reset aborts any frame in flight.
    always_ff @(posedge UART_CLK) begin
        if (!UART_RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_ready <= '0;
            r_idle  <= 1'b1;
            r_data  <= '0;
            r_id    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_ready <= w_ready_nxt;
            r_idle  <= w_idle_nxt;
            r_data  <= w_data_nxt;
            r_id    <= w_id_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state: grant -> send frame -> optional idle gap -> back to idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_nxt = S_SEND;
                end
            end
            S_SEND: begin
                if (w_frame_last) begin
                    w_state_nxt = HAS_GAP ? S_GAP : S_IDLE;
                end
            end
            S_GAP: begin
                if (w_gap_last) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next output/datapath values; data and id hold between grants.
    always_comb begin
        w_ready_nxt = '0;
        w_done_nxt  = 1'b0;
        w_idle_nxt  = r_idle;
        w_data_nxt  = r_data;
        w_id_nxt    = r_id;
        w_busy_nxt  = r_busy;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ready_nxt = N_REQ'(1) << w_pick;
                    w_data_nxt  = w_bytes[w_pick];
                    w_id_nxt    = w_pick;
                    w_idle_nxt  = 1'b0;
                    w_busy_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_ptr_nxt   = (w_pick == ID_W'(N_REQ - 1)) ? '0 : w_pick + ID_W'(1);
                end
            end
            S_SEND: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_frame_last) begin
                    w_idle_nxt = 1'b1;
                    w_done_nxt = 1'b1;
                    w_cnt_nxt  = '0;
                    if (!HAS_GAP) begin
                        w_busy_nxt = 1'b0;
                    end
                end
            end
            S_GAP: begin
                w_cnt_nxt = r_cnt + CNT_W'(1);
                if (w_gap_last) begin
                    w_busy_nxt = 1'b0;
                    w_cnt_nxt  = '0;
                end
            end
            default: begin
                w_idle_nxt = 1'b1;
                w_busy_nxt = 1'b0;
                w_cnt_nxt  = '0;
            end
        endcase
    end

    assign REQ_READY  = r_ready;
    assign UART_IDLE  = r_idle;
    assign UART_DATA  = r_data;
    assign GRANT_ID   = r_id;
    assign BUSY       = r_busy;
    assign FRAME_DONE = r_done;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Randomized and directed bench for uart_tx_scheduler against a grant-timeline reference model.
module tb_uart_tx_scheduler;

    localparam int N  = 4;
    localparam int FR = 12;
    localparam int GP = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  valid;
    logic [31:0] data;
    logic [3:0]  ready;
    logic        uidle;
    logic [7:0]  udata;
    logic [1:0]  gid;
    logic        busy;
    logic        done;

    logic        valid2;
    logic [7:0]  data2;
    logic [0:0]  ready2;
    logic        uidle2;
    logic [7:0]  udata2;
    logic [0:0]  gid2;
    logic        busy2;
    logic        done2;

    always #5 clk = ~clk;

    uart_tx_scheduler #(.N_REQ(4), .FRAME_CYCLES(12), .GAP_CYCLES(2), .CNT_W(5)) dut (
        .UART_CLK(clk), .UART_RST_N(rst_n), .REQ_VALID(valid), .REQ_DATA(data),
        .REQ_READY(ready), .UART_IDLE(uidle), .UART_DATA(udata), .GRANT_ID(gid),
        .BUSY(busy), .FRAME_DONE(done)
    );

    uart_tx_scheduler #(.N_REQ(1), .FRAME_CYCLES(12), .GAP_CYCLES(0), .CNT_W(5)) dut2 (
        .UART_CLK(clk), .UART_RST_N(rst_n), .REQ_VALID(valid2), .REQ_DATA(data2),
        .REQ_READY(ready2), .UART_IDLE(uidle2), .UART_DATA(udata2), .GRANT_ID(gid2),
        .BUSY(busy2), .FRAME_DONE(done2)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int edge_n = 0;

    // Requester side: pending flag and byte per producer.
    bit       pend [N];
    bit [7:0] byt  [N];
    bit [7:0] byt2;

    // Model: time of last grant plus what was granted.
    bit       m_have;
    int       m_g;
    int       m_ptr;
    bit [7:0] m_data;
    int       m_id;
    bit       m2_have;
    int       m2_g;
    bit [7:0] m2_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp)
            $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, obs, exp);
        else
            n_pass++;
    endtask

    // One clock: drive inputs, advance the model at the edge, compare just after it.
    task automatic step(input bit rn);
        bit [3:0] smp;
        int d;
        bit [3:0] e_rdy;
        rst_n = rn;
        for (int i = 0; i < N; i++) begin
            valid[i]       = pend[i];
            data[8*i +: 8] = byt[i];
            smp[i]         = pend[i];
        end
        valid2 = 1'b1;
        data2  = byt2;
        @(posedge clk);
        edge_n++;
        if (!rn) begin
            m_have = 0; m_ptr = 0; m_data = 0; m_id = 0;
            m2_have = 0; m2_data = 0;
        end else begin
            if (!m_have || edge_n >= m_g + FR + GP + 1) begin
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (m_ptr + k) % N;
                    if (smp[c]) begin
                        m_have = 1; m_g = edge_n; m_data = byt[c]; m_id = c;
                        m_ptr = (c + 1) % N;
                        pend[c] = 0;
                        break;
                    end
                end
            end
            if (!m2_have || edge_n >= m2_g + FR + 1) begin
                m2_have = 1; m2_g = edge_n; m2_data = byt2;
                byt2 = 8'($urandom);
            end
        end
        #1;
        d = edge_n - m_g;
        e_rdy = (m_have && d == 0) ? 4'(1 << m_id) : 4'd0;
        chk("idle",  32'(uidle), 32'(!(m_have && d < FR)));
        chk("busy",  32'(busy),  32'(m_have && d < FR + GP));
        chk("done",  32'(done),  32'(m_have && d == FR));
        chk("ready", 32'(ready), 32'(e_rdy));
        chk("data",  32'(udata), 32'(m_data));
        chk("gid",   32'(gid),   32'(m_id));
        d = edge_n - m2_g;
        chk("n1_idle",  32'(uidle2), 32'(!(m2_have && d < FR)));
        chk("n1_busy",  32'(busy2),  32'(m2_have && d < FR));
        chk("n1_done",  32'(done2),  32'(m2_have && d == FR));
        chk("n1_ready", 32'(ready2), 32'(m2_have && d == 0));
        chk("n1_data",  32'(udata2), 32'(m2_data));
        chk("n1_gid",   32'(gid2),   32'd0);
        @(negedge clk);
    endtask

    initial begin
        bit reached;
        rst_n = 1'b0; valid = '0; data = '0; valid2 = 1'b0; data2 = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 0; byt[i] = 0; end
        byt2 = 8'h5A;
        m_have = 0; m_g = 0; m_ptr = 0; m_data = 0; m_id = 0;
        m2_have = 0; m2_g = 0; m2_data = 0;
        @(negedge clk);
        step(0); step(0);

        // Single requester 2 with A5.
        pend[2] = 1; byt[2] = 8'hA5;
        repeat (20) step(1);

        // All four valid from reset: order 11,22,33,44 spaced 15 cycles.
        step(0);
        for (int i = 0; i < N; i++) begin pend[i] = 1; byt[i] = 8'(8'h11 * (i + 1)); end
        repeat (65) step(1);

        // Req0 continuously valid, req3 arrives mid-frame.
        for (int t = 0; t < 50; t++) begin
            if (!pend[0]) begin pend[0] = 1; byt[0] = 8'($urandom); end
            if (t == 5) begin pend[3] = 1; byt[3] = 8'h3C; end
            step(1);
        end
        pend[0] = 0;
        repeat (20) step(1);

        // Reset at frame cycle 5, then a fresh request.
        pend[1] = 1; byt[1] = 8'h77;
        reached = 0;
        for (int t = 0; t < 40 && !reached; t++) begin
            step(1);
            if (m_have && edge_n - m_g == 5) reached = 1;
        end
        chk("t4_reach", 32'(reached), 32'd1);
        step(0);
        pend[1] = 1; byt[1] = 8'h99;
        repeat (20) step(1);

        // One-cycle VALID pulse while busy is never granted.
        pend[0] = 1; byt[0] = 8'hE1;
        repeat (4) step(1);
        pend[3] = 1; byt[3] = 8'hBD;
        step(1);
        pend[3] = 0;
        repeat (25) step(1);

        // Random traffic with requester drops and occasional reset.
        for (int t = 0; t < 2500; t++) begin
            for (int i = 0; i < N; i++) begin
                if (pend[i] && $urandom_range(15) == 0) pend[i] = 0;
                else if (!pend[i] && $urandom_range(3) == 0) begin
                    pend[i] = 1; byt[i] = 8'($urandom);
                end
            end
            step($urandom_range(299) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
